norm_shift_pipe: RTL and testbench



---
 rtl/norm_shift_pipe.sv | 165 ++++++++++++++++
 tb/tb_norm_shift_pipe.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_pipe.sv
// Two-stage valid/ready significand normaliser: counts leading zeros, left-justifies the
// mantissa and lowers the exponent, with subnormal clamp or flush-to-zero on underflow.
module norm_shift_pipe #(
  parameter int unsigned  MANT_W     = 53,
  parameter int unsigned  EXP_W      = 11,
  parameter bit           SUBNORM_EN = 1'b1,
  localparam int unsigned SH_W       = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [MANT_W-1:0] in_mant_i,
  input  logic [EXP_W-1:0]  in_exp_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [MANT_W-1:0] out_mant_o,
  output logic [EXP_W-1:0]  out_exp_o,
  output logic [SH_W-1:0]   out_shift_o,
  output logic              out_zero_o,
  output logic              out_uflow_o
);

  // Common width so the lzc/exponent comparison never truncates either operand.
  localparam int unsigned CMP_W = (SH_W > EXP_W) ? SH_W : EXP_W;

  function automatic logic [SH_W-1:0] count_lz(input logic [MANT_W-1:0] m);
    logic [SH_W-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) begin
          found = 1'b1;
        end else begin
          n = n + SH_W'(1);
        end
      end
    end
    return n;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
  logic [SH_W-1:0]   s1_lzc_q, s1_lzc_d;
  logic              s1_zero_q, s1_zero_d;

  logic              s2_valid_q, s2_valid_d;
  logic [MANT_W-1:0] s2_mant_q, s2_mant_d;
  logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
  logic [SH_W-1:0]   s2_shift_q, s2_shift_d;
  logic              s2_zero_q, s2_zero_d;
  logic              s2_uflow_q, s2_uflow_d;

  logic              s2_adv;
  logic              s1_load;
  logic              s2_load;

  logic [CMP_W-1:0]  lzc_ext;
  logic [CMP_W-1:0]  exp_ext;
  logic [MANT_W-1:0] res_mant;
  logic [EXP_W-1:0]  res_exp;
  logic [SH_W-1:0]   res_shift;
  logic              res_zero;
  logic              res_uflow;

  assign s2_adv     = ~s2_valid_q | out_ready_i;
  assign in_ready_o = ~s1_valid_q | s2_adv;
  assign s1_load    = in_valid_i & in_ready_o;
  assign s2_load    = s1_valid_q & s2_adv;

  always_comb begin
    s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
    s1_mant_d  = s1_mant_q;
    s1_exp_d   = s1_exp_q;
    s1_lzc_d   = s1_lzc_q;
    s1_zero_d  = s1_zero_q;
    if (s1_load) begin
      s1_mant_d = in_mant_i;
      s1_exp_d  = in_exp_i;
      s1_lzc_d  = count_lz(in_mant_i);
      s1_zero_d = ~|in_mant_i;
    end
  end

  // Shift is bounded by lzc in every branch, so no set bit is ever pushed out the top.
  always_comb begin
    lzc_ext   = CMP_W'(s1_lzc_q);
    exp_ext   = CMP_W'(s1_exp_q);
    res_mant  = '0;
    res_exp   = '0;
    res_shift = '0;
    res_zero  = 1'b0;
    res_uflow = 1'b0;
    if (s1_zero_q) begin
      res_zero = 1'b1;
    end else if (lzc_ext <= exp_ext) begin
      res_shift = s1_lzc_q;
      res_mant  = s1_mant_q << s1_lzc_q;
      res_exp   = EXP_W'(exp_ext - lzc_ext);
    end else begin
      res_uflow = 1'b1;
      if (SUBNORM_EN) begin
        res_shift = SH_W'(s1_exp_q);
        res_mant  = s1_mant_q << res_shift;
      end else begin
        res_shift = s1_lzc_q;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_mant_d  = s2_mant_q;
    s2_exp_d   = s2_exp_q;
    s2_shift_d = s2_shift_q;
    s2_zero_d  = s2_zero_q;
    s2_uflow_d = s2_uflow_q;
    if (s2_load) begin
      s2_mant_d  = res_mant;
      s2_exp_d   = res_exp;
      s2_shift_d = res_shift;
      s2_zero_d  = res_zero;
      s2_uflow_d = res_uflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lzc_q   <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mant_q  <= s1_mant_d;
      s1_exp_q   <= s1_exp_d;
      s1_lzc_q   <= s1_lzc_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_mant_q  <= s2_mant_d;
      s2_exp_q   <= s2_exp_d;
      s2_shift_q <= s2_shift_d;
      s2_zero_q  <= s2_zero_d;
      s2_uflow_q <= s2_uflow_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_mant_o  = s2_mant_q;
  assign out_exp_o   = s2_exp_q;
  assign out_shift_o = s2_shift_q;
  assign out_zero_o  = s2_zero_q;
  assign out_uflow_o = s2_uflow_q;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe: one clamp-to-subnormal and one flush-to-zero
// instance share stimulus and are checked against a bit-serial normalisation model.
module tb_norm_shift_pipe;

  localparam int unsigned MW = 53;
  localparam int unsigned EW = 11;
  localparam int unsigned SW = 6;
  localparam int unsigned PW = MW + EW + SW + 2;

  typedef struct {
    logic [MW-1:0] mant;
    logic [MW-1:0] mant_f;
    logic [EW-1:0] exp;
    logic [SW-1:0] sh;
    logic [SW-1:0] sh_f;
    logic          zero;
    logic          uflow;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_ready = 1'b0;

  logic          in_ready_s, out_valid_s, out_zero_s, out_uflow_s;
  logic [MW-1:0] out_mant_s;
  logic [EW-1:0] out_exp_s;
  logic [SW-1:0] out_shift_s;
  logic          in_ready_f, out_valid_f, out_zero_f, out_uflow_f;
  logic [MW-1:0] out_mant_f;
  logic [EW-1:0] out_exp_f;
  logic [SW-1:0] out_shift_f;
  logic [PW-1:0] act_s, act_f;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  assign act_s = {out_mant_s, out_exp_s, out_shift_s, out_zero_s, out_uflow_s};
  assign act_f = {out_mant_f, out_exp_f, out_shift_f, out_zero_f, out_uflow_f};

  norm_shift_pipe #(.MANT_W(MW), .EXP_W(EW), .SUBNORM_EN(1'b1)) u_sub (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_s), .in_mant_i(in_mant), .in_exp_i(in_exp),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready), .out_mant_o(out_mant_s),
    .out_exp_o(out_exp_s), .out_shift_o(out_shift_s), .out_zero_o(out_zero_s),
    .out_uflow_o(out_uflow_s)
  );

  norm_shift_pipe #(.MANT_W(MW), .EXP_W(EW), .SUBNORM_EN(1'b0)) u_ftz (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_f), .in_mant_i(in_mant), .in_exp_i(in_exp),
    .out_valid_o(out_valid_f), .out_ready_i(out_ready), .out_mant_o(out_mant_f),
    .out_exp_o(out_exp_f), .out_shift_o(out_shift_f), .out_zero_o(out_zero_f),
    .out_uflow_o(out_uflow_f)
  );

  // Normalise one bit at a time, stopping when the MSB is set or the exponent reaches 0.
  function automatic exp_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    exp_t r;
    int   lz;
    int   ex;
    r  = '{default: '0};
    lz = 0;
    while (lz < int'(MW) && m[MW-1-lz] == 1'b0) lz++;
    if (m == '0) begin
      r.zero = 1'b1;
      return r;
    end
    r.mant = m;
    ex     = int'(e);
    while (!r.mant[MW-1] && ex > 0) begin
      r.mant = r.mant << 1;
      ex--;
      r.sh = r.sh + SW'(1);
    end
    r.exp    = EW'(ex);
    r.uflow  = ~r.mant[MW-1];
    r.mant_f = r.uflow ? '0 : r.mant;
    r.sh_f   = r.uflow ? SW'(lz) : r.sh;
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_sub(input exp_t r);
    return {r.mant, r.exp, r.sh, r.zero, r.uflow};
  endfunction

  function automatic logic [PW-1:0] pack_ftz(input exp_t r);
    return {r.mant_f, r.exp, r.sh_f, r.zero, r.uflow};
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_valid_s !== 1'b0 || act_s !== '0 || out_valid_f !== 1'b0 || act_f !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got valid=%b/%b payload=%h/%h required 0", out_valid_s,
               out_valid_f, act_s, act_f);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid_s !== 1'b0 || act_s !== '0 || in_ready_s !== 1'b1 || in_ready_f !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b payload=%h in_ready=%b/%b required 0,0,1,1",
               out_valid_s, act_s, in_ready_s, in_ready_f);
    end
  endtask

  task automatic test_directed();
    logic [MW-1:0] vm[6];
    logic [EW-1:0] ve[6];
    vm[0] = MW'(1) << 52; ve[0] = 11'd1023;
    vm[1] = MW'(1);       ve[1] = 11'd100;
    vm[2] = MW'(1);       ve[2] = 11'd10;
    vm[3] = '0;           ve[3] = 11'd500;
    vm[4] = MW'(1);       ve[4] = 11'd52;
    vm[5] = MW'(5) << 40; ve[5] = 11'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_mant   = vm[i];
      in_exp    = ve[i];
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready_s !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_in_ready[%0d]: got %b required 1", i, in_ready_s);
      end
      sb.push_back(model(vm[i], ve[i]));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid_s !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_early_valid[%0d]: got %b required 0", i, out_valid_s);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid_s !== 1'b1 || out_valid_f !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got valid=%b/%b required 1/1", i, out_valid_s,
                 out_valid_f);
      end
      n_checks++;
      if (act_s !== pack_sub(sb[0])) begin
        n_fail++;
        $display("FAIL directed_sub[%0d]: got %h required %h", i, act_s, pack_sub(sb[0]));
      end
      n_checks++;
      if (act_f !== pack_ftz(sb[0])) begin
        n_fail++;
        $display("FAIL directed_ftz[%0d]: got %h required %h", i, act_f, pack_ftz(sb[0]));
      end
      void'(sb.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] mants[8];
    logic [EW-1:0] exps[8];
    logic          rdy_pat[4];
    logic          exp_rdy;
    int            sent;
    int            got;
    int            cyc;
    bit            saw_full;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; got = 0; cyc = 0; saw_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mants[i] = MW'({$urandom, $urandom} >> $urandom_range(0, 63));
      exps[i]  = EW'($urandom_range(0, 70));
    end
    mants[3] = '0;
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_mant = mants[sent];
        in_exp  = exps[sent];
      end
      out_ready = (sent < 8) ? rdy_pat[cyc % 4] : 1'b1;
      @(negedge clk);
      exp_rdy = (sb.size() < 2) || out_ready;
      n_checks++;
      if (in_ready_s !== exp_rdy || in_ready_f !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b_in_ready[cyc %0d]: got %b/%b required %b", cyc, in_ready_s,
                 in_ready_f, exp_rdy);
      end
      if (in_ready_s === 1'b0) saw_full = 1'b1;
      if (out_valid_s === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_beat[cyc %0d]: got payload %h required no beat", cyc, act_s);
        end else begin
          if (act_s !== pack_sub(sb[0]) || act_f !== pack_ftz(sb[0])) begin
            n_fail++;
            $display("FAIL b2b_payload[beat %0d]: got %h/%h required %h/%h", got, act_s, act_f,
                     pack_sub(sb[0]), pack_ftz(sb[0]));
          end
          if (out_ready) begin
            void'(sb.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready_s === 1'b1) begin
        sb.push_back(model(in_mant, in_exp));
        sent++;
      end
      cyc++;
    end
    n_checks++;
    if (got != 8 || sent != 8 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: got sent=%0d emitted=%0d left=%0d required 8,8,0", sent, got,
               sb.size());
    end
    n_checks++;
    if (!saw_full) begin
      n_fail++;
      $display("FAIL b2b_backpressure: got in_ready never low required at least one stall");
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = MW'(3) << 7;
    in_exp    = 11'd60;
    @(posedge clk); #1;
    in_mant = MW'(9);
    in_exp  = 11'd900;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_setup: got valid=%b in_ready=%b required 1,0", out_valid_s,
               in_ready_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_s !== 1'b0 || out_valid_f !== 1'b0 || act_s !== '0 || act_f !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b/%b payload=%h/%h required 0", out_valid_s,
               out_valid_f, act_s, act_f);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid_s !== 1'b0 || out_valid_f !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_stale[%0d]: got valid=%b/%b required 0", i, out_valid_s,
                 out_valid_f);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mant  = MW'(1) << 20;
    in_exp   = 11'd200;
    sb.push_back(model(in_mant, in_exp));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid_s !== 1'b1 || act_s !== pack_sub(sb[0]) || act_f !== pack_ftz(sb[0])) begin
      n_fail++;
      $display("FAIL areset_recover: got valid=%b payload=%h/%h required 1 %h/%h", out_valid_s,
               act_s, act_f, pack_sub(sb[0]), pack_ftz(sb[0]));
    end
    void'(sb.pop_front());
    @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
